gen_fifo_fwft_out: RTL and testbench

Read-side output stage that sits directly downstream of the FIFO controller and its storage array. It turns the controller's pop/rd_ptr read interface, where read data returns a fixed RD_LAT cycles after pop, into a first-word-fall-through valid/ready stream. It prefetches words into a small output buffer so that out_vld is high whenever data exists. Sustains 1 word/cycle under continuous out_rdy when BUF_DEPTH >= RD_LAT+1.

---
 rtl/gen_fifo_pkg.sv | 11 +
 rtl/gen_cnt_top.sv | 34 +++
 rtl/gen_fifo_fwft_buf.sv | 61 ++++++
 rtl/gen_fifo_fwft_out.sv | 63 ++++++
 tb/tb_gen_fifo_fwft_out.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_fifo_pkg.sv
// Shared helpers for the generic FIFO block family.
package gen_fifo_pkg;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gen_cnt_top.sv
// Up/down counter wrapping between 0 and LIM, with synchronous clear.
module gen_cnt_top #(
  parameter int unsigned W   = 4,
  parameter int unsigned LIM = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = (cnt_q == W'(LIM)) ? '0 : cnt_q + W'(1);
    end else if (dec && !inc) begin
      cnt_d = (cnt_q == '0) ? W'(LIM) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gen_fifo_fwft_buf.sv
// Circular output buffer: register array plus read/write indices and occupancy.
module gen_fifo_fwft_buf #(
  parameter  int unsigned DAT_W     = 32,
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1),
  localparam int unsigned IDX_W     = $clog2(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             enq,
  input  logic [DAT_W-1:0] wr_dat,
  input  logic             deq_req,
  output logic [DAT_W-1:0] rd_dat,
  output logic [OCC_W-1:0] occ,
  output logic             err_ovfl
);

  logic [DAT_W-1:0] mem_d [BUF_DEPTH];
  logic [DAT_W-1:0] mem_q [BUF_DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, deq, wr_en;
  logic             err_ovfl_d, err_ovfl_q;

  assign full  = (occ == OCC_W'(BUF_DEPTH));
  assign deq   = deq_req & (occ != '0) & ~clr;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign wr_en = enq & (~full | deq) & ~clr;
  assign err_ovfl_d = enq & full & ~deq & ~clr;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      err_ovfl_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      err_ovfl_q <= err_ovfl_d;
    end
  end

  gen_cnt_top #(.W(IDX_W), .LIM(BUF_DEPTH - 1)) u_wr_idx (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(wr_en), .dec(1'b0), .cnt(wr_idx)
  );

  gen_cnt_top #(.W(IDX_W), .LIM(BUF_DEPTH - 1)) u_rd_idx (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(deq), .dec(1'b0), .cnt(rd_idx)
  );

  gen_cnt_top #(.W(OCC_W), .LIM(BUF_DEPTH)) u_occ (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(wr_en), .dec(deq), .cnt(occ)
  );

  assign rd_dat   = mem_q[rd_idx];
  assign err_ovfl = err_ovfl_q;

endmodule

// File: rtl/gen_fifo_fwft_out.sv
// First-word-fall-through output stage: prefetches from a fixed-latency FIFO
// read port into a small buffer, issuing pops only when a slot is guaranteed.
module gen_fifo_fwft_out
  import gen_fifo_pkg::*;
#(
  parameter  int unsigned DAT_W     = 32,
  parameter  int unsigned RD_LAT    = 1,
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [DAT_W-1:0] fifo_rd_dat,
  output logic             out_vld,
  output logic [DAT_W-1:0] out_dat,
  input  logic             out_rdy,
  output logic [OCC_W-1:0] sts_occ,
  output logic             err_ovfl
);

  localparam int unsigned CW = OCC_W + 1;

  logic [RD_LAT-1:0] rd_vld_d, rd_vld_q;
  logic [CW-1:0]     inflight, need;
  logic              deq, enq;

  assign out_vld = (sts_occ != '0);
  assign deq     = out_vld & out_rdy;
  assign enq     = rd_vld_q[RD_LAT-1];

  // Credit: buffered + in-flight - leaving must stay below depth after this pop.
  always_comb begin
    inflight = CW'(popcnt4(4'(rd_vld_q)));
    need     = CW'(sts_occ) + inflight - CW'(deq);
    fifo_pop = rst_n & ~clr & ~fifo_empty & (need < CW'(BUF_DEPTH));
    rd_vld_d = '0;
    if (!clr) begin
      rd_vld_d[0] = fifo_pop;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= '0;
    else        rd_vld_q <= rd_vld_d;
  end

  gen_fifo_fwft_buf #(.DAT_W(DAT_W), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .enq      (enq),
    .wr_dat   (fifo_rd_dat),
    .deq_req  (deq),
    .rd_dat   (out_dat),
    .occ      (sts_occ),
    .err_ovfl (err_ovfl)
  );

endmodule

// File: tb/tb_gen_fifo_fwft_out.sv
// Scoreboard bench for gen_fifo_fwft_out: instance A (RD_LAT=1, depth 2) and
// instance B (RD_LAT=2, depth 3), each fed by a behavioural FIFO/storage model.
`timescale 1ns/1ps
module tb_gen_fifo_fwft_out;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          clr_a, empty_a, pop_a, vld_a, rdy_a, err_a;
  logic [DW-1:0] rdat_a, odat_a;
  logic [1:0]    occ_a;
  logic          clr_b, empty_b, pop_b, vld_b, rdy_b, err_b;
  logic [DW-1:0] rdat_b, odat_b, pipe_b0;
  logic [1:0]    occ_b;

  logic [DW-1:0] mem_a[$], pend_a[$], exp_a[$];
  logic [DW-1:0] mem_b[$], pend_b[$], exp_b[$];
  logic          pop_s_a, clr_s_a, pop_s_b, clr_s_b;

  int unsigned total = 0, bad = 0;
  int unsigned pops_a = 0, pops_b = 0, hs_a = 0, hs_b = 0, vcnt_a = 0;
  int unsigned pop_empty = 0, ovfl_seen = 0, occ_over = 0;

  gen_fifo_fwft_out #(.DAT_W(DW), .RD_LAT(1), .BUF_DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .fifo_empty(empty_a), .fifo_pop(pop_a),
    .fifo_rd_dat(rdat_a), .out_vld(vld_a), .out_dat(odat_a), .out_rdy(rdy_a),
    .sts_occ(occ_a), .err_ovfl(err_a)
  );

  gen_fifo_fwft_out #(.DAT_W(DW), .RD_LAT(2), .BUF_DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .fifo_empty(empty_b), .fifo_pop(pop_b),
    .fifo_rd_dat(rdat_b), .out_vld(vld_b), .out_dat(odat_b), .out_rdy(rdy_b),
    .sts_occ(occ_b), .err_ovfl(err_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: samples 2ns before each rising edge, pops the scoreboard on handshakes.
  always begin
    @(negedge clk); #3;
    pop_s_a = pop_a; clr_s_a = clr_a;
    pop_s_b = pop_b; clr_s_b = clr_b;
    if (rst_n === 1'b1) begin
      if (pop_a && empty_a) pop_empty++;
      if (pop_b && empty_b) pop_empty++;
      if (err_a || err_b) ovfl_seen++;
      if (occ_a > 2'd2 || occ_b > 2'd3) occ_over++;
      if (pop_a) pops_a++;
      if (pop_b) pops_b++;
      if (vld_a) vcnt_a++;
      if (vld_a && rdy_a && !clr_a) begin
        hs_a++;
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL out_a: got=%h exp=<none>", odat_a);
        end else chk("out_a", odat_a, exp_a.pop_front());
      end
      if (vld_b && rdy_b && !clr_b) begin
        hs_b++;
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL out_b: got=%h exp=<none>", odat_b);
        end else chk("out_b", odat_b, exp_b.pop_front());
      end
    end
  end

  // FIFO controller + storage models; a clr flushes the controller too.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a.delete(); pend_a.delete(); exp_a.delete();
      empty_a <= 1'b1; rdat_a <= '0;
    end else begin
      if (clr_s_a) begin
        mem_a.delete(); exp_a.delete();
      end else if (pop_s_a && mem_a.size() > 0) rdat_a <= mem_a.pop_front();
      while (pend_a.size() > 0) mem_a.push_back(pend_a.pop_front());
      empty_a <= (mem_a.size() == 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_b.delete(); pend_b.delete(); exp_b.delete();
      empty_b <= 1'b1; rdat_b <= '0; pipe_b0 <= '0;
    end else begin
      rdat_b <= pipe_b0;
      if (clr_s_b) begin
        mem_b.delete(); exp_b.delete();
        pipe_b0 <= 32'hDEAD_BEEF;
      end else if (pop_s_b && mem_b.size() > 0) pipe_b0 <= mem_b.pop_front();
      else pipe_b0 <= 32'hDEAD_BEEF;
      while (pend_b.size() > 0) mem_b.push_back(pend_b.pop_front());
      empty_b <= (mem_b.size() == 0);
    end
  end

  task automatic push_a(input logic [DW-1:0] w); pend_a.push_back(w); exp_a.push_back(w); endtask
  task automatic push_b(input logic [DW-1:0] w); pend_b.push_back(w); exp_b.push_back(w); endtask
  task automatic step(input int unsigned n); repeat (n) @(posedge clk); #2; endtask
  task automatic mid(); @(negedge clk); #1; endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  vld_v, pop_v;
    int unsigned base_p, base_h, base_v;
    bit          found;

    rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    step(3);
    mid();
    chk("rst_vld", 32'(vld_a), 32'd0);
    chk("rst_occ", 32'(occ_a), 32'd0);
    chk("rst_pop", 32'(pop_a), 32'd0);
    chk("rst_dat", odat_a, 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Four preloaded words, continuous ready: first word two cycles after first pop.
    step(1);
    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) push_a(32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      mid();
      vld_v[i] = vld_a;
      pop_v[i] = pop_a;
    end
    chk("t1_vld_pattern", 32'(vld_v), 32'h78);
    chk("t1_pop_pattern", 32'(pop_v), 32'h1E);
    step(1);

    // Stalled output: only BUF_DEPTH pops, head held stable.
    rdy_a = 1'b0;
    base_p = pops_a;
    for (int i = 0; i < 10; i++) push_a(32'h100 + 32'(i));
    step(8);
    mid();
    chk("t2_pops", pops_a - base_p, 32'd2);
    chk("t2_occ", 32'(occ_a), 32'd2);
    chk("t2_vld", 32'(vld_a), 32'd1);
    chk("t2_head", odat_a, 32'h100);
    step(3);
    mid();
    chk("t2_head_hold", odat_a, 32'h100);
    chk("t2_pops_hold", pops_a - base_p, 32'd2);
    step(1);
    rdy_a = 1'b1;
    base_h = hs_a;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_rate", hs_a - base_h, 32'd10);
    mid();
    chk("t2_drained_vld", 32'(vld_a), 32'd0);
    chk("t2_sb_empty", 32'(exp_a.size()), 32'd0);
    step(1);

    // Single word into an empty FIFO.
    base_p = pops_a;
    base_v = vcnt_a;
    push_a(32'h5A);
    step(8);
    chk("t3_pops", pops_a - base_p, 32'd1);
    chk("t3_vld_cycles", vcnt_a - base_v, 32'd1);
    chk("t3_occ", 32'(occ_a), 32'd0);

    // clr with two buffered and one in flight on instance B.
    rdy_b = 1'b0;
    base_p = pops_b;
    for (int i = 0; i < 5; i++) push_b(32'h200 + 32'(i));
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      mid();
      if (occ_b == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reach_occ2", 32'(found), 32'd1);
    chk("t5_pops_before", pops_b - base_p, 32'd3);
    clr_b = 1'b1;
    @(posedge clk); #2;
    clr_b = 1'b0;
    mid();
    chk("t5_clr_vld", 32'(vld_b), 32'd0);
    chk("t5_clr_occ", 32'(occ_b), 32'd0);
    step(1);
    base_h = hs_b;
    push_b(32'h300);
    push_b(32'h301);
    rdy_b = 1'b1;
    step(10);
    chk("t5_post_clr_cnt", hs_b - base_h, 32'd2);
    chk("t5_sb_empty", 32'(exp_b.size()), 32'd0);

    // 100 words through instance B under random backpressure.
    base_h = hs_b;
    for (int i = 0; i < 100; i++) push_b(32'h1000 + 32'(i));
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      rdy_b = 1'($urandom_range(0, 1));
      if (exp_b.size() == 0) break;
    end
    step(2);
    chk("t4_drain", 32'(exp_b.size()), 32'd0);
    chk("t4_count", hs_b - base_h, 32'd100);
    rdy_b = 1'b0;

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < 6; i++) push_a(32'h400 + 32'(i));
    step(3);
    chk("t6_pre_vld", 32'(vld_a), 32'd1);
    chk("t6_pre_pop", 32'(pop_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(vld_a), 32'd0);
    chk("t6_rst_pop", 32'(pop_a), 32'd0);
    chk("t6_rst_occ", 32'(occ_a), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("t6_after_vld", 32'(vld_a), 32'd0);

    chk("pop_while_empty", pop_empty, 32'd0);
    chk("err_ovfl_seen", ovfl_seen, 32'd0);
    chk("occ_bound", occ_over, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
